// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a classic 5-stage in-order pipeline.
// Detects load-use, branch-operand and mul/div (HI/LO) hazards, produces
// stall/flush controls, and sequences edge-triggered interrupt acceptance.
//
// Parameters:
//   REG_W      register-index width
//   LOAD_STALL bubble cycles per load-use hazard (1..3)
//   MD_LAT     mul/div busy cycles after start (2..63)
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   id_rs, id_rt                ID source register indices
//   id_use_rs, id_use_rt        ID source actually read
//   id_branch, id_jump          ID control-transfer type
//   id_md_use                   ID reads HI/LO or starts mul/div
//   ex_memrd, ex_regwrite       EX is a load / writes a register
//   ex_dst                      resolved EX destination
//   mem_memrd, mem_dst          MEM-stage load and its destination
//   md_start                    mul/div launched this cycle
//   irq                         level interrupt request
//   stall_pc, stall_if_id       hold PC and IF/ID register
//   flush_if_id, flush_id_ex    squash IF/ID or insert bubble into ID/EX
//   irq_take                    interrupt accepted this cycle
//   md_busy                     mul/div unit still computing
module pipe_hazard_ctrl #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned MD_LAT     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             id_md_use,
    input  logic             ex_memrd,
    input  logic             ex_regwrite,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             mem_memrd,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             md_start,
    input  logic             irq,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             irq_take,
    output logic             md_busy
);

    localparam logic [1:0] LD_INIT = 2'(LOAD_STALL - 1);
    localparam logic [5:0] MD_INIT = 6'(MD_LAT);

    // Register 0 is hardwired zero, so it never creates a dependency.
    function automatic logic match(input logic [REG_W-1:0] x, input logic [REG_W-1:0] y);
        return (x == y) && (x != '0);
    endfunction

    logic [1:0] ld_cnt_q, ld_cnt_d;
    logic [5:0] md_cnt_q, md_cnt_d;
    logic       irq_q;
    logic       irq_pend_q, irq_pend_d;

    logic ex_hit, mem_hit;
    logic load_hz, br_hz, md_hz, stall;
    logic jb_flush, take, irq_edge;

    always_comb begin
        ex_hit   = (id_use_rs && match(ex_dst, id_rs)) || (id_use_rt && match(ex_dst, id_rt));
        mem_hit  = (id_use_rs && match(mem_dst, id_rs)) || (id_use_rt && match(mem_dst, id_rt));
        load_hz  = ex_memrd && ex_hit;
        br_hz    = id_branch && ((ex_regwrite && ex_hit) || (mem_memrd && mem_hit));
        md_hz    = id_md_use && (md_cnt_q != '0);
        stall    = load_hz || (ld_cnt_q != '0) || br_hz || md_hz;
        // A stalled branch re-evaluates next cycle; only then is the fetch squashed.
        jb_flush = !stall && (id_jump || id_branch);
        take     = irq_pend_q && !stall && !jb_flush;
        irq_edge = irq && !irq_q;
    end

    always_comb begin
        if (load_hz) begin
            ld_cnt_d = LD_INIT;
        end else if (ld_cnt_q != '0) begin
            ld_cnt_d = ld_cnt_q - 2'd1;
        end else begin
            ld_cnt_d = '0;
        end

        if (md_start) begin
            md_cnt_d = MD_INIT;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 6'd1;
        end else begin
            md_cnt_d = '0;
        end

        // An edge arriving in the take cycle must survive the clear.
        irq_pend_d = (irq_pend_q && !take) || irq_edge;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt_q   <= '0;
            md_cnt_q   <= '0;
            irq_q      <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            ld_cnt_q   <= ld_cnt_d;
            md_cnt_q   <= md_cnt_d;
            irq_q      <= irq;
            irq_pend_q <= irq_pend_d;
        end
    end

    // Outputs are forced low for the whole reset cycle, even mid-stall.
    always_comb begin
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        irq_take    = 1'b0;
        md_busy     = 1'b0;
        if (!reset) begin
            stall_pc    = stall;
            stall_if_id = stall;
            flush_if_id = jb_flush || take;
            flush_id_ex = stall || take;
            irq_take    = take;
            md_busy     = (md_cnt_q != '0);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int REG_W      = 5;
    localparam int LOAD_STALL = 2;
    localparam int MD_LAT     = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_dst, mem_dst;
    logic             id_use_rs, id_use_rt, id_branch, id_jump, id_md_use;
    logic             ex_memrd, ex_regwrite, mem_memrd, md_start, irq;
    logic             stall_pc, stall_if_id, flush_if_id, flush_id_ex, irq_take, md_busy;

    pipe_hazard_ctrl #(
        .REG_W      (REG_W),
        .LOAD_STALL (LOAD_STALL),
        .MD_LAT     (MD_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_branch   (id_branch),
        .id_jump     (id_jump),
        .id_md_use   (id_md_use),
        .ex_memrd    (ex_memrd),
        .ex_regwrite (ex_regwrite),
        .ex_dst      (ex_dst),
        .mem_memrd   (mem_memrd),
        .mem_dst     (mem_dst),
        .md_start    (md_start),
        .irq         (irq),
        .stall_pc    (stall_pc),
        .stall_if_id (stall_if_id),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .irq_take    (irq_take),
        .md_busy     (md_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: stall windows tracked as absolute cycle numbers.
    int cyc         = 0;
    int ld_until    = -1;      // last cycle covered by a load-use bubble window
    int md_launch   = -1000;   // cycle in which the last mul/div was launched
    bit irq_prev    = 0;
    bit pend        = 0;
    bit m_load_hz, m_take;

    logic [5:0] last_got;      // {stall_pc, stall_if_id, flush_if_id, flush_id_ex, irq_take, md_busy}

    function automatic bit dep(input int d, input int s, input bit used);
        return used && (d == s) && (d != 0);
    endfunction

    task automatic idle();
        id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
        id_branch = 0; id_jump = 0; id_md_use = 0;
        ex_memrd = 0; ex_regwrite = 0; ex_dst = '0;
        mem_memrd = 0; mem_dst = '0; md_start = 0;
    endtask

    task automatic step(input string tag);
        logic [5:0] exp, got;
        bit ex_dep, mem_dep, br_hz, busy, md_hz, stall, jb, take;
        @(negedge clk);
        ex_dep  = dep(int'(ex_dst), int'(id_rs), id_use_rs) || dep(int'(ex_dst), int'(id_rt), id_use_rt);
        mem_dep = dep(int'(mem_dst), int'(id_rs), id_use_rs) || dep(int'(mem_dst), int'(id_rt), id_use_rt);
        m_load_hz = ex_memrd && ex_dep;
        br_hz   = id_branch && ((ex_regwrite && ex_dep) || (mem_memrd && mem_dep));
        busy    = (cyc > md_launch) && (cyc <= md_launch + MD_LAT);
        md_hz   = id_md_use && busy;
        stall   = m_load_hz || (cyc <= ld_until) || br_hz || md_hz;
        jb      = !stall && (id_jump || id_branch);
        take    = pend && !stall && !jb;
        m_take  = take && !reset;
        if (reset) exp = '0;
        else exp = {stall, stall, jb || take, stall || take, take, busy};
        got = {stall_pc, stall_if_id, flush_if_id, flush_id_ex, irq_take, md_busy};
        last_got = got;
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
        @(posedge clk);
        if (reset) begin
            ld_until = -1; md_launch = -1000; irq_prev = 0; pend = 0;
        end else begin
            if (m_load_hz) ld_until = cyc + LOAD_STALL - 1;
            if (md_start) md_launch = cyc;
            pend = (pend && !m_take) || (irq && !irq_prev);
            irq_prev = irq;
        end
        cyc++;
        #1;
    endtask

    task automatic expect_count(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    int n;

    initial begin
        idle(); irq = 0; reset = 1;
        #1;
        step("reset0");
        step("reset1");
        reset = 0;
        step("idle");

        // r0 never forms a dependency; unused source never forms one either
        ex_memrd = 1; ex_dst = 0; id_rs = 0; id_use_rs = 1;
        step("ld_r0");
        ex_dst = 9; id_rt = 9; id_use_rs = 0; id_use_rt = 0;
        step("ld_unused_rt");
        idle();
        step("idle2");

        // load-use on r8: two bubble cycles, then released
        ex_memrd = 1; ex_dst = 8; id_rs = 8; id_use_rs = 1;
        n = 0;
        step("ld_use0"); n += int'(last_got[5]);
        ex_memrd = 0;
        step("ld_use1"); n += int'(last_got[5]);
        step("ld_use2"); n += int'(last_got[5]);
        expect_count("ld_use_len", n, 2);
        expect_count("ld_release", int'(last_got[5]), 0);
        idle();

        // branch reading rt=4 written in EX: one stall, then flush
        id_branch = 1; ex_regwrite = 1; ex_dst = 4; id_rt = 4; id_use_rt = 1;
        step("br_hz");
        expect_count("br_hz_noflush", int'(last_got[3]), 0);
        ex_regwrite = 0;
        step("br_go");
        expect_count("br_go_flush", int'(last_got[3]), 1);
        idle();
        id_jump = 1; mem_memrd = 1; mem_dst = 3; id_rs = 3; id_use_rs = 1;
        step("jump");
        idle();

        // mul/div busy window with consumer waiting
        md_start = 1;
        step("md_start");
        md_start = 0; id_md_use = 1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step("md_wait");
            n += int'(last_got[5]);
        end
        expect_count("md_stall_len", n, 4);
        expect_count("md_release", int'(last_got[0]), 0);
        idle();

        // irq rises in the load-detect cycle; take waits for stall to end
        ex_memrd = 1; ex_dst = 8; id_rs = 8; id_use_rs = 1; irq = 1;
        n = 0;
        step("irq_ld0"); n += int'(last_got[1]);
        idle();
        for (int i = 0; i < 6; i++) begin
            step("irq_hold");
            n += int'(last_got[1]);
        end
        expect_count("irq_single_pulse", n, 1);
        irq = 0;
        step("irq_low");

        // reset mid mul/div, with irq high across reset release
        md_start = 1;
        step("md2_start");
        md_start = 0; id_md_use = 1;
        step("md2_cnt4");
        reset = 1; irq = 1;
        step("md2_reset");
        reset = 0;
        step("md2_after");
        expect_count("md2_busy_clear", int'(last_got[0]), 0);
        step("irq_after_reset");
        expect_count("irq_after_reset_take", int'(last_got[1]), 1);
        idle(); irq = 0;
        step("idle3");

        // randomized traffic with a small register set to provoke matches
        for (int i = 0; i < 600; i++) begin
            id_rs       = REG_W'($urandom_range(0, 3));
            id_rt       = REG_W'($urandom_range(0, 3));
            ex_dst      = REG_W'($urandom_range(0, 3));
            mem_dst     = REG_W'($urandom_range(0, 3));
            id_use_rs   = 1'($urandom_range(0, 1));
            id_use_rt   = 1'($urandom_range(0, 1));
            id_branch   = ($urandom_range(0, 3) == 0);
            id_jump     = ($urandom_range(0, 5) == 0);
            id_md_use   = ($urandom_range(0, 2) == 0);
            ex_memrd    = ($urandom_range(0, 3) == 0);
            ex_regwrite = 1'($urandom_range(0, 1));
            mem_memrd   = ($urandom_range(0, 3) == 0);
            md_start    = ($urandom_range(0, 11) == 0);
            irq         = ($urandom_range(0, 3) == 0) ? ~irq : irq;
            reset       = ($urandom_range(0, 63) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have parameter LOAD_STALL, default 1, bubble cycles per load-use hazard (legal 1..3).
REQ-003 SHALL have parameter MD_LAT, default 32, mul/div busy cycles after start (legal 2..63).
REQ-004 SHALL have ports: clk in 1 clock; reset in 1 sync active-high reset, one clock, all state on rising clk edge.
REQ-005 SHALL have ports: id_rs, id_rt in REG_W ID source indices; id_use_rs, id_use_rt in 1 source actually read.
REQ-006 SHALL have ports: id_branch, id_jump in 1 ID control; id_md_use in 1 ID reads HI/LO or starts mul/div.
REQ-007 SHALL have ports: ex_memrd, ex_regwrite in 1; ex_dst in REG_W resolved EX destination.
REQ-008 SHALL have ports: mem_memrd in 1; mem_dst in REG_W MEM-stage load destination.
REQ-009 SHALL have ports: md_start in 1 mul/div launched this cycle; irq in 1 level interrupt request.
REQ-010 SHALL have outputs: stall_pc, stall_if_id, flush_if_id, flush_id_ex, irq_take, md_busy, each 1 bit.

Function
REQ-011 SHALL define match(x,y) = (x==y) and (x!=0); rs/rt hits qualified by id_use_rs/id_use_rt.
REQ-012 SHALL detect load-use when ex_memrd and match(ex_dst, used ID source); load stall counter with LOAD_STALL-1 at next edge.
REQ-013 SHALL, during detect cycle and while load counter >0, assert stall_pc, stall_if_id, flush_id_ex; counter decrements per cycle, saturates at 0.
REQ-014 SHALL detect branch-operand hazard when id_branch and (ex_regwrite and match(ex_dst, src) or mem_memrd and match(mem_dst, src)); assert stall_pc, stall_if_id, flush_id_ex that cycle, no counter.
REQ-015 SHALL, with id_jump, or id_branch and no stall condition, assert flush_if_id for exactly that cycle.
REQ-016 SHALL load md counter with MD_LAT on md_start; md_busy = (counter!=0); decrement per cycle; md_start while busy reloads MD_LAT.
REQ-017 SHALL, when id_md_use and md_busy, assert stall_pc, stall_if_id, flush_id_ex; md_busy drops on the cycle counter reaches 0 and stall releases same cycle.
REQ-018 SHALL register irq (irq_q) and set irq_pend on irq and not irq_q; held-high irq SHALL NOT re-arm until seen low.
REQ-019 SHALL assert irq_take one cycle when irq_pend and no stall (REQ-012..017) and no flush_if_id from REQ-015; irq_pend clears at that edge.
REQ-020 SHALL assert flush_if_id and flush_id_ex on irq_take cycle; new edge in same cycle as take SHALL re-set irq_pend.
REQ-021 SHALL prioritise: stall conditions over jump/branch flush over irq_take; id_jump never stalls.
REQ-022 SHALL OR simultaneous stall sources; longest remaining counter governs release.
REQ-023 SHALL keep stall_pc == stall_if_id in every cycle.

Reset
REQ-024 SHALL clear load counter, md counter, irq_q, irq_pend at edge with reset high.
REQ-025 SHALL drive all outputs 0 combinationally while reset high, including mid-stall or mid-mul/div.
REQ-026 SHALL, first cycle after reset, hold irq_q=0 so irq already high is taken as a new edge.

Verification
REQ-027 SHALL test LOAD_STALL=2: ex_memrd=1, ex_dst=8, id_rs=8, id_use_rs=1 -> stall_pc/flush_id_ex high 2 cycles, then 0.
REQ-028 SHALL test ex_dst=0 load with id_rs=0 -> no stall; id_use_rt=0 with ex_dst=id_rt=9 -> no stall.
REQ-029 SHALL test id_branch, ex_regwrite, ex_dst=id_rt=4 -> 1-cycle stall, no flush_if_id; next cycle flush_if_id=1.
REQ-030 SHALL test MD_LAT=4: md_start, then id_md_use held -> md_busy 4 cycles, stall 4 cycles, released on 5th.
REQ-031 SHALL test irq rising during load stall -> irq_take delayed to first stall-free cycle, single pulse, irq held high yields no second pulse.
REQ-032 SHALL test reset asserted mid mul/div (counter=3) -> outputs 0 immediately, md_busy 0 after edge, no residual stall.
